// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: latches up to N_SRC device requests, presents the
// highest-priority eligible one on a registered irq line, with claim/EOI priority nesting.
module irq_ctrl #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             we,
  input  logic             re,
  input  logic [2:0]       addr,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [N_SRC-1:0] irq_src,
  output logic             irq
);

  localparam logic [2:0] OFF_PEND   = 3'd0;
  localparam logic [2:0] OFF_EN     = 3'd1;
  localparam logic [2:0] OFF_MODE   = 3'd2;
  localparam logic [2:0] OFF_CLAIM  = 3'd3;
  localparam logic [2:0] OFF_INSERV = 3'd4;

  logic [N_SRC-1:0] src_q_r;
  logic [N_SRC-1:0] pend_r;
  logic [N_SRC-1:0] en_r;
  logic [N_SRC-1:0] mode_r;
  logic [N_SRC-1:0] inserv_r;

  logic [N_SRC-1:0] pend_nx_s;
  logic [N_SRC-1:0] inserv_nx_s;
  logic [N_SRC-1:0] edge_s;
  logic [N_SRC-1:0] allow_s;
  logic [N_SRC-1:0] elig_s;
  logic             elig_any_s;
  logic [ID_W-1:0]  claim_id_s;
  logic [ID_W-1:0]  eoi_id_s;
  logic             wr_s;
  logic             rd_s;
  logic             w1c_s;
  logic             eoi_s;
  logic             claim_s;
  logic             unused_s;

  // A simultaneous read strobe loses to a write: no claim side effect then.
  assign wr_s     = sel & we & be[0];
  assign rd_s     = sel & re & ~we;
  assign w1c_s    = wr_s & (addr == OFF_PEND);
  assign eoi_s    = wr_s & (addr == OFF_CLAIM);
  assign eoi_id_s = wdata[ID_W-1:0];
  assign edge_s   = irq_src & ~src_q_r;
  assign unused_s = ^{be[3:1], wdata[31:N_SRC]};

  // Priority window: source i may interrupt only if nothing at index <= i is in service.
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    allow_s = '0;
    for (int i = 0; i < N_SRC; i++) begin
      blocked    = blocked | inserv_r[i];
      allow_s[i] = ~blocked;
    end
  end

  assign elig_s     = pend_r & en_r & ~inserv_r & allow_s;
  assign elig_any_s = |elig_s;

  // Lowest-index eligible source is the one presented for claiming.
  always_comb begin
    claim_id_s = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig_s[i]) claim_id_s = ID_W'(i);
      else           claim_id_s = claim_id_s;
    end
  end

  assign claim_s = rd_s & (addr == OFF_CLAIM) & elig_any_s;

  // Next PENDING/INSERV: level bits mirror the input; edge sets beat W1C and claim clears.
  always_comb begin
    pend_nx_s   = pend_r;
    inserv_nx_s = inserv_r;
    for (int i = 0; i < N_SRC; i++) begin
      if (!mode_r[i])                                pend_nx_s[i] = irq_src[i];
      else if (edge_s[i])                            pend_nx_s[i] = 1'b1;
      else if (w1c_s && wdata[i])                    pend_nx_s[i] = 1'b0;
      else if (claim_s && (claim_id_s == ID_W'(i)))  pend_nx_s[i] = 1'b0;
      else                                           pend_nx_s[i] = pend_r[i];

      if (claim_s && (claim_id_s == ID_W'(i)))       inserv_nx_s[i] = 1'b1;
      else if (eoi_s && (eoi_id_s == ID_W'(i)))      inserv_nx_s[i] = 1'b0;
      else                                           inserv_nx_s[i] = inserv_r[i];
    end
  end

  // Register state; irq is the registered OR of eligible sources.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q_r  <= '0;
      pend_r   <= '0;
      en_r     <= '0;
      mode_r   <= '0;
      inserv_r <= '0;
      irq      <= 1'b0;
    end else begin
      src_q_r  <= irq_src;
      pend_r   <= pend_nx_s;
      inserv_r <= inserv_nx_s;
      irq      <= elig_any_s;
      if (wr_s && (addr == OFF_EN))   en_r   <= wdata[N_SRC-1:0];
      else                            en_r   <= en_r;
      if (wr_s && (addr == OFF_MODE)) mode_r <= wdata[N_SRC-1:0];
      else                            mode_r <= mode_r;
    end
  end

  // Combinational read mux; CLAIM shows {valid, id} of the winning source.
  always_comb begin
    rdata = 32'h0000_0000;
    if (sel) begin
      case (addr)
        OFF_PEND:   rdata = 32'(pend_r);
        OFF_EN:     rdata = 32'(en_r);
        OFF_MODE:   rdata = 32'(mode_r);
        OFF_CLAIM:  rdata = elig_any_s ? {1'b1, {(31-ID_W){1'b0}}, claim_id_s} : 32'h0000_0000;
        OFF_INSERV: rdata = 32'(inserv_r);
        default:    rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl; expected values go through a scoreboard queue.
module tb_irq_ctrl;
  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             sel;
  logic             we;
  logic             re;
  logic [2:0]       addr;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic [N_SRC-1:0] irq_src;
  logic             irq;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_asrt = 0;
  int   n_fail = 0;

  irq_ctrl #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .re(re), .addr(addr), .be(be),
    .wdata(wdata), .rdata(rdata), .irq_src(irq_src), .irq(irq)
  );

  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_asrt++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %h expected none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b = 4'h1);
    sel = 1'b1; we = 1'b1; be = b; addr = a; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0; be = 4'h0; wdata = 32'h0;
  endtask

  task automatic bus_rd(input logic [2:0] a, input string tag, input logic [31:0] exp);
    push_exp(tag, exp);
    sel = 1'b1; re = 1'b1; addr = a;
    #2;
    check(rdata);
    tick();
    sel = 1'b0; re = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    push_exp(tag, {31'h0, exp});
    check({31'h0, irq});
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; we = 1'b0; re = 1'b0; addr = 3'd0; be = 4'h0;
    wdata = 32'h0; irq_src = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state and byte-enable gating
    bus_rd(3'd0, "rst_pend", 32'h0);
    bus_rd(3'd1, "rst_en", 32'h0);
    bus_rd(3'd2, "rst_mode", 32'h0);
    bus_rd(3'd3, "rst_claim", 32'h0);
    bus_rd(3'd4, "rst_inserv", 32'h0);
    chk_irq("rst_irq", 1'b0);
    bus_wr(3'd1, 32'hFF, 4'hE);
    bus_rd(3'd1, "be0_gate", 32'h0);

    // Single edge source 3
    bus_wr(3'd1, 32'h08);
    bus_wr(3'd2, 32'h08);
    irq_src = 8'h08;
    tick();
    irq_src = 8'h00;
    chk_irq("edge_irq_k", 1'b0);
    bus_rd(3'd0, "edge_pend_k", 32'h08);
    chk_irq("edge_irq_k1", 1'b1);
    sel = 1'b0; addr = 3'd1;
    push_exp("rdata_nosel", 32'h0);
    #1;
    check(rdata);
    bus_rd(3'd3, "claim3", 32'h8000_0003);
    bus_rd(3'd0, "claim3_pend", 32'h0);
    bus_rd(3'd4, "claim3_inserv", 32'h08);
    chk_irq("claim3_irq", 1'b0);
    bus_wr(3'd3, 32'd3);
    bus_rd(3'd4, "eoi3_inserv", 32'h0);

    // Nesting by priority
    bus_wr(3'd1, 32'hFF);
    bus_wr(3'd2, 32'hFF);
    irq_src = 8'h24;
    tick();
    irq_src = 8'h00;
    tick();
    bus_rd(3'd0, "nest_pend", 32'h24);
    chk_irq("nest_irq", 1'b1);
    bus_rd(3'd3, "nest_claim2", 32'h8000_0002);
    tick(); tick();
    chk_irq("nest_blocked5", 1'b0);
    bus_rd(3'd4, "nest_inserv4", 32'h04);
    bus_wr(3'd3, 32'd2);
    tick();
    chk_irq("nest_reopen", 1'b1);
    bus_rd(3'd3, "nest_claim5", 32'h8000_0005);
    tick(); tick();
    chk_irq("nest_idle", 1'b0);
    bus_rd(3'd4, "nest_inserv20", 32'h20);
    irq_src = 8'h02;
    tick();
    irq_src = 8'h00;
    tick();
    chk_irq("nest_preempt", 1'b1);
    bus_rd(3'd3, "nest_claim1", 32'h8000_0001);
    bus_rd(3'd4, "nest_inserv22", 32'h22);
    bus_wr(3'd3, 32'd1);
    bus_wr(3'd3, 32'd5);
    bus_rd(3'd4, "nest_inserv0", 32'h0);
    bus_rd(3'd0, "nest_pend0", 32'h0);

    // Level-mode source 0
    bus_wr(3'd2, 32'hFE);
    irq_src = 8'h01;
    tick(); tick();
    bus_rd(3'd0, "lvl_pend", 32'h01);
    bus_wr(3'd0, 32'h01);
    bus_rd(3'd0, "lvl_w1c_kept", 32'h01);
    chk_irq("lvl_irq", 1'b1);
    bus_rd(3'd3, "lvl_claim0", 32'h8000_0000);
    tick(); tick();
    chk_irq("lvl_claimed_irq", 1'b0);
    bus_rd(3'd0, "lvl_claim_kept", 32'h01);
    bus_rd(3'd4, "lvl_inserv", 32'h01);
    bus_wr(3'd3, 32'd0);
    tick();
    chk_irq("lvl_eoi_irq", 1'b1);
    irq_src = 8'h00;
    tick();
    bus_rd(3'd0, "lvl_drop", 32'h0);
    tick();
    chk_irq("lvl_drop_irq", 1'b0);

    // Collisions and masking
    bus_wr(3'd2, 32'hFF);
    irq_src = 8'h10;
    sel = 1'b1; we = 1'b1; be = 4'h1; addr = 3'd0; wdata = 32'h10;
    tick();
    sel = 1'b0; we = 1'b0; be = 4'h0; wdata = 32'h0;
    irq_src = 8'h00;
    bus_rd(3'd0, "col_set_wins", 32'h10);
    bus_wr(3'd1, 32'h00);
    tick();
    chk_irq("mask_irq", 1'b0);
    bus_rd(3'd3, "mask_claim", 32'h0);
    bus_rd(3'd0, "mask_pend", 32'h10);
    bus_rd(3'd4, "mask_inserv", 32'h0);
    bus_wr(3'd1, 32'hFF);
    bus_rd(3'd3, "col_claim4", 32'h8000_0004);
    bus_wr(3'd3, 32'd6);
    bus_rd(3'd4, "eoi6_ignored", 32'h10);

    // Reset mid-operation
    irq_src = 8'h0F;
    tick();
    irq_src = 8'h00;
    tick();
    bus_rd(3'd0, "pre_rst_pend", 32'h0F);
    chk_irq("pre_rst_irq", 1'b1);
    rst = 1'b1;
    tick();
    chk_irq("rst2_irq", 1'b0);
    rst = 1'b0;
    bus_rd(3'd0, "rst2_pend", 32'h0);
    bus_rd(3'd1, "rst2_en", 32'h0);
    bus_rd(3'd2, "rst2_mode", 32'h0);
    bus_rd(3'd4, "rst2_inserv", 32'h0);
    bus_rd(3'd3, "rst2_claim", 32'h0);
    chk_irq("rst2_irq_end", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Programmable interrupt controller on the bridge's peripheral bus.
- Collects up to N_SRC device interrupt sources and latches them as pending.
- Picks the highest-priority eligible source and drives one registered request line into one HWInt bit of the MIPS core.
- The CPU claims the interrupt through a register read and retires it with an end-of-interrupt (EOI) write; nesting is strictly by priority.

Parameters:
- N_SRC, 8, number of interrupt sources (1..8); index 0 is the highest priority.
- ID_W, 3, width of a source ID.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- sel  input  1  bridge device select for this block.
- we  input  1  write strobe; valid only with sel.
- re  input  1  read strobe, single cycle; valid only with sel; read side effects happen only on re.
- addr  input  3  word offset (PrAddr[4:2]).
- be  input  4  byte enables; only be[0] matters, all registers are 8 bits wide.
- wdata  input  32  write data.
- rdata  output  32  combinational read data; 0 when sel=0 or the offset is unmapped.
- irq_src  input  N_SRC  device requests, synchronous to clk.
- irq  output  1  registered interrupt request to a CPU HWInt bit.

Behaviour:
- Register map (word offset):
  - 0 PENDING: read; write-1-to-clear, edge-mode bits only.
  - 1 ENABLE: read/write.
  - 2 MODE: read/write; 1 = edge, 0 = level.
  - 3 CLAIM: a read claims; a write is an EOI.
  - 4 INSERV: read-only.
- Writes take effect only when sel & we & be[0]. Bits at or above N_SRC read 0 and ignore writes.
- Reset: src_q, PENDING, ENABLE, MODE, INSERV and irq all 0.
- Edge mode:
  - The block registers irq_src into src_q every cycle.
  - edge = irq_src & ~src_q; an edge sets the PENDING bit at that clock edge.
  - The bit stays set until cleared by a W1C write or a claim.
- Level mode: PENDING[i] <= irq_src[i] every cycle; W1C writes and claims do not clear it.
- Eligibility:
  - elig[i] = PENDING[i] & ENABLE[i] & ~INSERV[i] & (i < lowest set INSERV index, or INSERV == 0).
  - irq <= |elig, registered.
  - Latency: a source rising before edge k sets PENDING at k, and irq rises at k+1.
- CLAIM read:
  - rdata = {elig_any, 23'b0, 5'b0, id} with id = lowest-index eligible source; {elig_any, ...} gives 32'h8000_000id.
  - If elig_any: at the clock edge INSERV[id] <= 1, and PENDING[id] <= 0 if the source is edge mode.
  - If nothing is eligible: rdata = 0 and no state changes.
- EOI write to offset 3: INSERV[wdata[ID_W-1:0]] <= 0. Ignored if that bit is already clear or the ID is >= N_SRC.
- Simultaneous events:
  - Edge set and W1C on the same bit in one cycle: set wins.
  - New edge on the same source as a claim in one cycle: PENDING stays 1.
  - EOI and claim in the same cycle cannot occur (one bus op per cycle); if we and re are both asserted, the write wins and the read has no side effect.
- Masking:
  - Clearing ENABLE drops irq on the next edge, but PENDING is retained.
  - Changing MODE from edge to level: PENDING follows irq_src from the next cycle.
- Nesting: while INSERV[j] is set, only sources i < j can raise irq. EOI reopens lower priorities on the following cycle.
- Reset asserted mid-operation clears all state at the next edge; irq is 0 from that edge on.

Test Plan:
- Reset, then read all offsets -> every register and rdata = 0, irq = 0.
- ENABLE=0x08, MODE=0x08, pulse irq_src[3] for 1 cycle at edge k:
  - PENDING=0x08 at k, irq=1 at k+1.
  - CLAIM read returns 0x8000_0003; PENDING=0, INSERV=0x08, irq=0 next cycle.
  - EOI 3 -> INSERV=0.
- Nesting: ENABLE=0xFF, all edge mode, pulse sources 5 and 2 together:
  - Claim returns 2; pending 5 does not raise irq.
  - EOI 2 -> irq=1; claim returns 5.
  - With INSERV=0x20, pulse source 1 -> irq=1; claim returns 1.
- Level mode source 0 held high:
  - W1C 0x01 and claim leave PENDING=1.
  - After claim, irq=0 until EOI 0, then irq=1 again.
  - Drop irq_src[0] -> PENDING=0 next cycle.
- Collisions:
  - Edge on source 4 in the same cycle as W1C 0x10 -> PENDING[4]=1.
  - Claim read with ENABLE=0 -> returns 0 and no state change.
  - EOI for ID 6 with INSERV[6]=0 -> no change.
- Assert rst with PENDING=0x0F and INSERV=0x10 -> all registers 0 at the next edge, irq=0.
